i2c_slave_core: RTL and testbench

- Synthesizable I2C target (slave), the responding end of the bus driven by the team's I2C master.
- Oversamples SCL/SDA on the core clock, detects START/STOP, matches a 7-bit address, ACKs, and exposes a register-pointer byte interface to user logic.
- Sits between the open-drain pads and a register bank. Replaces the behavioural slave model in synthesizable and system builds.

---
 rtl/i2c_slave_core.sv | 224 ++++++++++++++++++++++
 tb/tb_i2c_slave_core.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_core.sv
//------------------------------------------------------------------------------
// i2c_slave_core
//   Synthesizable I2C target. Oversamples SCL/SDA on the core clock, detects
//   START/STOP, matches a 7-bit address, ACKs, and presents a register-pointer
//   byte interface to user logic.
//
//   Ports:
//     i2c_core_clk_i  core clock (>= 10x SCL)
//     i2c_core_rst_i  synchronous reset, active high
//     scl_i, sda_i    asynchronous pad inputs
//     sda_oe_o        1 = pull SDA low (open drain)
//     wr_en_o         one-cycle pulse per received write data byte
//     wr_addr_o       register address for wr_en_o
//     wr_data_o       data byte for wr_en_o
//     rd_addr_o       current pointer; rd_data_i must answer combinationally
//     rd_data_i       read data for rd_addr_o
//     busy_o          high while this target is addressed
//
//   Build option: define I2C_SLAVE_GCALL_EN to also ACK the general-call
//   write address (byte 8'h00).
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module i2c_slave_core #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         PTR_W      = 8
) (
    input  logic             i2c_core_clk_i,
    input  logic             i2c_core_rst_i,
    input  logic             scl_i,
    input  logic             sda_i,
    output logic             sda_oe_o,
    output logic             wr_en_o,
    output logic [PTR_W-1:0] wr_addr_o,
    output logic [7:0]       wr_data_o,
    output logic [PTR_W-1:0] rd_addr_o,
    input  logic [7:0]       rd_data_i,
    output logic             busy_o
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
    } state_t;

    state_t             state, state_nx;

    // [0],[1] = 2-FF synchronizer, [2] = delay stage for edge detection
    logic [2:0]         scl_pipe, sda_pipe;

    logic [3:0]         bitcnt, bitcnt_nx;
    logic [7:0]         shreg, shreg_nx;
    logic [PTR_W-1:0]   ptr, ptr_nx;
    logic               rw, rw_nx;
    logic               sda_oe_nx, busy_nx, wr_en_nx;
    logic [PTR_W-1:0]   wr_addr_nx;
    logic [7:0]         wr_data_nx;

    logic               scl_rise, scl_fall, start_det, stop_det, sda_bit;
    logic [7:0]         byte_in;
    logic               addr_match;

    assign scl_rise  =  scl_pipe[1] & ~scl_pipe[2];
    assign scl_fall  = ~scl_pipe[1] &  scl_pipe[2];
    assign start_det =  scl_pipe[1] &  scl_pipe[2] & ~sda_pipe[1] &  sda_pipe[2];
    assign stop_det  =  scl_pipe[1] &  scl_pipe[2] &  sda_pipe[1] & ~sda_pipe[2];
    assign sda_bit   =  sda_pipe[1];
    assign byte_in   = {shreg[6:0], sda_bit};

`ifdef I2C_SLAVE_GCALL_EN
    assign addr_match = (byte_in[7:1] == SLAVE_ADDR) || (byte_in == 8'h00);
`else
    assign addr_match = (byte_in[7:1] == SLAVE_ADDR);
`endif

    assign rd_addr_o = ptr;

    // State and datapath registers
    always_ff @(posedge i2c_core_clk_i) begin
        if (i2c_core_rst_i) begin
            scl_pipe  <= 3'b111;
            sda_pipe  <= 3'b111;
            state     <= IDLE;
            bitcnt    <= '0;
            shreg     <= '0;
            ptr       <= '0;
            rw        <= 1'b0;
            sda_oe_o  <= 1'b0;
            busy_o    <= 1'b0;
            wr_en_o   <= 1'b0;
            wr_addr_o <= '0;
            wr_data_o <= '0;
        end else begin
            scl_pipe  <= {scl_pipe[1:0], scl_i};
            sda_pipe  <= {sda_pipe[1:0], sda_i};
            state     <= state_nx;
            bitcnt    <= bitcnt_nx;
            shreg     <= shreg_nx;
            ptr       <= ptr_nx;
            rw        <= rw_nx;
            sda_oe_o  <= sda_oe_nx;
            busy_o    <= busy_nx;
            wr_en_o   <= wr_en_nx;
            wr_addr_o <= wr_addr_nx;
            wr_data_o <= wr_data_nx;
        end
    end

    // Next state. STOP beats everything, including a coincident SCL edge.
    // In the ACK states the current sda_oe_o tells which fall this is:
    // released -> the fall that starts the ACK bit, driven -> the one ending it.
    always_comb begin
        state_nx = state;
        if (stop_det) begin
            state_nx = IDLE;
        end else if (start_det) begin
            state_nx = ADDR;
        end else begin
            case (state)
                ADDR:      if (scl_rise && bitcnt == 4'd7) state_nx = addr_match ? ADDR_ACK : IDLE;
                ADDR_ACK:  if (scl_fall && sda_oe_o)       state_nx = rw ? RDATA : PTR;
                PTR:       if (scl_rise && bitcnt == 4'd7) state_nx = PTR_ACK;
                PTR_ACK:   if (scl_fall && sda_oe_o)       state_nx = WDATA;
                WDATA:     if (scl_rise && bitcnt == 4'd7) state_nx = WDATA_ACK;
                WDATA_ACK: if (scl_fall && sda_oe_o)       state_nx = WDATA;
                RDATA:     if (scl_fall && bitcnt == 4'd8) state_nx = RDATA_ACK;
                RDATA_ACK: begin
                    if (scl_rise && sda_bit)                    state_nx = IDLE;
                    else if (scl_fall && bitcnt == 4'd1)        state_nx = RDATA;
                end
                default:   state_nx = state;
            endcase
        end
    end

    // Datapath / output next values
    always_comb begin
        bitcnt_nx  = bitcnt;
        shreg_nx   = shreg;
        ptr_nx     = ptr;
        rw_nx      = rw;
        sda_oe_nx  = sda_oe_o;
        busy_nx    = busy_o;
        wr_en_nx   = 1'b0;
        wr_addr_nx = wr_addr_o;
        wr_data_nx = wr_data_o;

        // pointer advances the cycle after a write strobe
        if (wr_en_o)
            ptr_nx = ptr + PTR_W'(1);

        if (stop_det || start_det) begin
            sda_oe_nx = 1'b0;
            busy_nx   = 1'b0;
            bitcnt_nx = '0;
        end else begin
            case (state)
                ADDR, PTR, WDATA: begin
                    if (scl_rise) begin
                        shreg_nx  = byte_in;
                        bitcnt_nx = bitcnt + 4'd1;
                        if (bitcnt == 4'd7) begin
                            bitcnt_nx = '0;
                            case (state)
                                ADDR: begin
                                    rw_nx   = sda_bit;
                                    busy_nx = addr_match;
                                end
                                PTR:  ptr_nx = PTR_W'(byte_in);
                                WDATA: begin
                                    wr_en_nx   = 1'b1;
                                    wr_addr_nx = ptr;
                                    wr_data_nx = byte_in;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_o) begin
                            sda_oe_nx = 1'b1;
                        end else begin
                            sda_oe_nx = 1'b0;
                            bitcnt_nx = '0;
                            // read: first byte goes out right as the ACK bit ends
                            if (state == ADDR_ACK && rw) begin
                                shreg_nx  = rd_data_i;
                                sda_oe_nx = ~rd_data_i[7];
                            end
                        end
                    end
                end
                RDATA: begin
                    if (scl_rise) begin
                        bitcnt_nx = bitcnt + 4'd1;
                    end else if (scl_fall) begin
                        if (bitcnt == 4'd8) begin
                            sda_oe_nx = 1'b0;
                            bitcnt_nx = '0;
                        end else begin
                            shreg_nx  = {shreg[6:0], 1'b0};
                            sda_oe_nx = ~shreg[6];
                        end
                    end
                end
                RDATA_ACK: begin
                    // pointer counts every byte sent, ACKed or not; bitcnt=1
                    // marks "master ACKed, load the next byte on the fall"
                    if (scl_rise) begin
                        ptr_nx = ptr + PTR_W'(1);
                        if (sda_bit) busy_nx   = 1'b0;
                        else         bitcnt_nx = 4'd1;
                    end else if (scl_fall && bitcnt == 4'd1) begin
                        shreg_nx  = rd_data_i;
                        sda_oe_nx = ~rd_data_i[7];
                        bitcnt_nx = '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave_core.sv
`timescale 1ns/1ps
module tb_i2c_slave_core;

    localparam int Q = 80;  // quarter SCL period in ns (8 core clocks)

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_bus;
    logic       sda_oe_o, wr_en_o, busy_o;
    logic [7:0] wr_addr_o, wr_data_o, rd_addr_o, rd_data_i;

    logic [7:0] bank  [256];
    logic [7:0] obs_a [256];
    logic [7:0] obs_d [256];
    logic [7:0] model_mem [256];
    int         wr_count = 0;
    int         oe_count = 0;
    int         n_tests  = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    assign sda_bus   = sda_m & ~sda_oe_o;
    assign rd_data_i = bank[rd_addr_o];

    i2c_slave_core dut (
        .i2c_core_clk_i (clk),
        .i2c_core_rst_i (rst),
        .scl_i          (scl_m),
        .sda_i          (sda_bus),
        .sda_oe_o       (sda_oe_o),
        .wr_en_o        (wr_en_o),
        .wr_addr_o      (wr_addr_o),
        .wr_data_o      (wr_data_o),
        .rd_addr_o      (rd_addr_o),
        .rd_data_i      (rd_data_i),
        .busy_o         (busy_o)
    );

    // register bank stand-in and write/drive observers
    always @(negedge clk) begin
        if (wr_en_o) begin
            obs_a[wr_count]   <= wr_addr_o;
            obs_d[wr_count]   <= wr_data_o;
            bank[wr_addr_o]   <= wr_data_o;
            wr_count          <= wr_count + 1;
        end
        if (sda_oe_o) oe_count <= oe_count + 1;
    end

    // ---------------- bus master ----------------
    task automatic bit_cycle(input logic b, output logic s);
        sda_m = b; #Q;
        scl_m = 1'b1; #Q;
        s = sda_bus; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic bus_start();
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b0; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b1; #Q;
        #Q;
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_cycle(d[i], s);
        bit_cycle(1'b1, s);
        ack = ~s;
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_cycle(1'b1, s);
            d[i] = s;
        end
        bit_cycle(nack, s);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++; if (sda_oe_o !== 1'b0) begin n_fail++; $display("FAIL rst_sda_oe: got %b exp 0", sda_oe_o); end
        n_tests++; if (wr_en_o !== 1'b0) begin n_fail++; $display("FAIL rst_wr_en: got %b exp 0", wr_en_o); end
        n_tests++; if (wr_addr_o !== 8'h00) begin n_fail++; $display("FAIL rst_wr_addr: got %h exp 00", wr_addr_o); end
        n_tests++; if (wr_data_o !== 8'h00) begin n_fail++; $display("FAIL rst_wr_data: got %h exp 00", wr_data_o); end
        n_tests++; if (rd_addr_o !== 8'h00) begin n_fail++; $display("FAIL rst_rd_addr: got %h exp 00", rd_addr_o); end
        n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b exp 0", busy_o); end
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_write();
        logic [3:0] acks;
        logic       busy_mid;
        int         base;
        base = wr_count;
        bus_start();
        send_byte(8'hA0, acks[0]);
        busy_mid = busy_o;
        send_byte(8'h10, acks[1]);
        send_byte(8'h3C, acks[2]);
        send_byte(8'h5A, acks[3]);
        bus_stop();
        model_mem[8'h10] = 8'h3C; model_mem[8'h11] = 8'h5A;
        n_tests++; if (acks !== 4'hF) begin n_fail++; $display("FAIL wr_acks: got %b exp 1111", acks); end
        n_tests++; if (busy_mid !== 1'b1) begin n_fail++; $display("FAIL wr_busy_mid: got %b exp 1", busy_mid); end
        n_tests++; if (wr_count - base !== 2) begin n_fail++; $display("FAIL wr_count: got %0d exp 2", wr_count - base); end
        n_tests++; if ({obs_a[base], obs_d[base]} !== 16'h103C) begin n_fail++; $display("FAIL wr_0: got %h/%h exp 10/3c", obs_a[base], obs_d[base]); end
        n_tests++; if ({obs_a[base+1], obs_d[base+1]} !== 16'h115A) begin n_fail++; $display("FAIL wr_1: got %h/%h exp 11/5a", obs_a[base+1], obs_d[base+1]); end
        n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL wr_busy_end: got %b exp 0", busy_o); end
        n_tests++; if (rd_addr_o !== 8'h12) begin n_fail++; $display("FAIL wr_ptr_end: got %h exp 12", rd_addr_o); end
    endtask

    task automatic test_read();
        logic       ack;
        logic [7:0] r [3];
        logic [7:0] d;
        // preload 0x20..0x22 with 0xB0|addr[3:0] through the bus
        bus_start();
        send_byte(8'hA0, ack); send_byte(8'h20, ack);
        for (int i = 0; i < 3; i++) send_byte(8'hB0 | 8'(i), ack);
        bus_stop();
        bus_start();
        send_byte(8'hA0, ack); send_byte(8'h20, ack);
        bus_start();
        send_byte(8'hA1, ack);
        n_tests++; if (ack !== 1'b1) begin n_fail++; $display("FAIL rd_addr_ack: got %b exp 1", ack); end
        for (int i = 0; i < 3; i++) begin
            recv_byte(i == 2, d);
            r[i] = d;
        end
        n_tests++; if (r[0] !== 8'hB0) begin n_fail++; $display("FAIL rd_b0: got %h exp b0", r[0]); end
        n_tests++; if (r[1] !== 8'hB1) begin n_fail++; $display("FAIL rd_b1: got %h exp b1", r[1]); end
        n_tests++; if (r[2] !== 8'hB2) begin n_fail++; $display("FAIL rd_b2: got %h exp b2", r[2]); end
        n_tests++; if (rd_addr_o !== 8'h23) begin n_fail++; $display("FAIL rd_ptr_end: got %h exp 23", rd_addr_o); end
        n_tests++; if (busy_o !== 1'b0 || sda_oe_o !== 1'b0) begin n_fail++; $display("FAIL rd_idle: got busy %b oe %b exp 0 0", busy_o, sda_oe_o); end
        bus_stop();
    endtask

    task automatic test_addr_nack();
        logic ack, a1, a2;
        int   base, oe0;
        base = wr_count; oe0 = oe_count;
        bus_start();
        send_byte(8'hA4, ack);
        send_byte(8'h10, a1);
        send_byte(8'h3C, a2);
        n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL nack_addr: got ack %b exp 0", ack); end
        n_tests++; if (oe_count - oe0 !== 0) begin n_fail++; $display("FAIL nack_oe: got %0d cycles exp 0", oe_count - oe0); end
        n_tests++; if (wr_count - base !== 0) begin n_fail++; $display("FAIL nack_wr: got %0d writes exp 0", wr_count - base); end
        n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL nack_busy: got %b exp 0", busy_o); end
        bus_stop();
    endtask

    task automatic test_wrap();
        logic ack;
        int   base;
        base = wr_count;
        bus_start();
        send_byte(8'hA0, ack); send_byte(8'hFF, ack);
        send_byte(8'h11, ack); send_byte(8'h22, ack);
        bus_stop();
        model_mem[8'hFF] = 8'h11; model_mem[8'h00] = 8'h22;
        n_tests++; if (wr_count - base !== 2) begin n_fail++; $display("FAIL wrap_count: got %0d exp 2", wr_count - base); end
        n_tests++; if (obs_a[base] !== 8'hFF) begin n_fail++; $display("FAIL wrap_a0: got %h exp ff", obs_a[base]); end
        n_tests++; if (obs_a[base+1] !== 8'h00) begin n_fail++; $display("FAIL wrap_a1: got %h exp 00", obs_a[base+1]); end
        n_tests++; if (rd_addr_o !== 8'h01) begin n_fail++; $display("FAIL wrap_ptr: got %h exp 01", rd_addr_o); end
    endtask

    task automatic test_abort();
        logic ack, s;
        int   base;
        // STOP after 4 data bits
        base = wr_count;
        bus_start();
        send_byte(8'hA0, ack); send_byte(8'h40, ack);
        for (int i = 0; i < 4; i++) bit_cycle(1'($urandom), s);
        bus_stop();
        n_tests++; if (sda_oe_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL stop_abort: got oe %b busy %b exp 0 0", sda_oe_o, busy_o); end
        n_tests++; if (wr_count - base !== 0) begin n_fail++; $display("FAIL stop_abort_wr: got %0d exp 0", wr_count - base); end
        bus_start();
        send_byte(8'hA0, ack); send_byte(8'h30, ack); send_byte(8'h99, ack);
        bus_stop();
        model_mem[8'h30] = 8'h99;
        n_tests++; if (wr_count - base !== 1 || {obs_a[base], obs_d[base]} !== 16'h3099) begin
            n_fail++; $display("FAIL stop_recover: got %0d writes %h/%h exp 1 30/99", wr_count - base, obs_a[base], obs_d[base]); end

        // reset mid-byte
        base = wr_count;
        bus_start();
        send_byte(8'hA0, ack); send_byte(8'h50, ack);
        for (int i = 0; i < 3; i++) bit_cycle(1'b0, s);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_tests++; if ({sda_oe_o, busy_o, wr_en_o} !== 3'b000) begin n_fail++; $display("FAIL rst_abort: got oe/busy/wr %b exp 000", {sda_oe_o, busy_o, wr_en_o}); end
        n_tests++; if (rd_addr_o !== 8'h00) begin n_fail++; $display("FAIL rst_abort_ptr: got %h exp 00", rd_addr_o); end
        bus_stop();
        n_tests++; if (wr_count - base !== 0) begin n_fail++; $display("FAIL rst_abort_wr: got %0d exp 0", wr_count - base); end
        bus_start();
        send_byte(8'hA0, ack); send_byte(8'h31, ack); send_byte(8'h66, ack);
        bus_stop();
        model_mem[8'h31] = 8'h66;
        n_tests++; if (wr_count - base !== 1 || {obs_a[base], obs_d[base]} !== 16'h3166) begin
            n_fail++; $display("FAIL rst_recover: got %0d writes %h/%h exp 1 31/66", wr_count - base, obs_a[base], obs_d[base]); end
    endtask

    task automatic test_random();
        logic [7:0] p, a, d, r;
        logic [7:0] wd [3];
        logic       ack, acks;
        int         n, base;
        for (int it = 0; it < 6; it++) begin
            p = 8'($urandom);
            n = $urandom_range(1, 3);
            base = wr_count;
            acks = 1'b1;
            bus_start();
            send_byte(8'hA0, ack); acks &= ack;
            send_byte(p, ack);     acks &= ack;
            for (int i = 0; i < n; i++) begin
                wd[i] = 8'($urandom);
                send_byte(wd[i], ack); acks &= ack;
                a = p + 8'(i);
                model_mem[a] = wd[i];
            end
            bus_stop();
            n_tests++; if (acks !== 1'b1) begin n_fail++; $display("FAIL rnd_acks[%0d]: got %b exp 1", it, acks); end
            n_tests++; if (wr_count - base !== n) begin n_fail++; $display("FAIL rnd_wcount[%0d]: got %0d exp %0d", it, wr_count - base, n); end
            for (int i = 0; i < n; i++) begin
                a = p + 8'(i);
                n_tests++; if (obs_a[base+i] !== a || obs_d[base+i] !== wd[i]) begin
                    n_fail++; $display("FAIL rnd_wr[%0d.%0d]: got %h/%h exp %h/%h", it, i, obs_a[base+i], obs_d[base+i], a, wd[i]); end
            end
            // read back from the same pointer after a repeated START
            bus_start();
            send_byte(8'hA0, ack); send_byte(p, ack);
            bus_start();
            send_byte(8'hA1, ack);
            for (int i = 0; i < n; i++) begin
                recv_byte(i == n - 1, r);
                a = p + 8'(i);
                d = model_mem[a];
                n_tests++; if (r !== d) begin n_fail++; $display("FAIL rnd_rd[%0d.%0d]: got %h exp %h", it, i, r, d); end
            end
            bus_stop();
            a = p + 8'(n);
            n_tests++; if (rd_addr_o !== a) begin n_fail++; $display("FAIL rnd_ptr[%0d]: got %h exp %h", it, rd_addr_o, a); end
        end
    endtask

    task automatic test_gcall();
        logic       ack, exp_gc;
        logic [7:0] exp_ptr;
        int         base;
`ifdef I2C_SLAVE_GCALL_EN
        exp_gc = 1'b1;
`else
        exp_gc = 1'b0;
`endif
        bus_start();
        send_byte(8'hA0, ack); send_byte(8'h33, ack);
        bus_stop();
        exp_ptr = exp_gc ? 8'h06 : 8'h33;
        base = wr_count;
        bus_start();
        send_byte(8'h00, ack);
        n_tests++; if (ack !== exp_gc) begin n_fail++; $display("FAIL gc_ack: got %b exp %b", ack, exp_gc); end
        send_byte(8'h05, ack); send_byte(8'h77, ack);
        bus_stop();
        n_tests++; if (wr_count - base !== int'(exp_gc)) begin n_fail++; $display("FAIL gc_wcount: got %0d exp %0d", wr_count - base, exp_gc); end
        if (wr_count > base) begin
            n_tests++; if ({obs_a[base], obs_d[base]} !== 16'h0577) begin n_fail++; $display("FAIL gc_wr: got %h/%h exp 05/77", obs_a[base], obs_d[base]); end
        end
        n_tests++; if (rd_addr_o !== exp_ptr) begin n_fail++; $display("FAIL gc_ptr: got %h exp %h", rd_addr_o, exp_ptr); end
        bus_start();
        send_byte(8'h01, ack);
        bus_stop();
        n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL gc_01_ack: got %b exp 0", ack); end
    endtask

    initial begin
        #800_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_write();
        test_read();
        test_addr_nack();
        test_wrap();
        test_abort();
        test_random();
        test_gcall();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
